sync_fifo_monitor: RTL

//  Synthesizable scoreboard/protocol monitor for a parametrised synchronous FIFO.

---
 rtl/sync_fifo_monitor_if.sv | 29 ++
 rtl/sync_fifo_monitor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_monitor_if.sv
// Signals observed on a synchronous FIFO: request strobes, data, flags, occupancy and pointers.
// The master modport drives the FIFO side and the slave modport is the monitor's view.
interface sync_fifo_monitor_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             fifo_write;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data_in;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [AW-1:0]    fifo_wr_ptr;
    logic [AW-1:0]    fifo_rd_ptr;

    modport master (
        output fifo_write, fifo_read, fifo_data_in, fifo_data_out,
               fifo_full, fifo_empty, fifo_cnt, fifo_wr_ptr, fifo_rd_ptr
    );

    modport slave (
        input fifo_write, fifo_read, fifo_data_in, fifo_data_out,
              fifo_full, fifo_empty, fifo_cnt, fifo_wr_ptr, fifo_rd_ptr
    );
endinterface

// File: rtl/sync_fifo_monitor.sv
// Shadow-model scoreboard for a synchronous FIFO; error bits are registered one cycle after the cycle checked.
// Purely observational: it never backpressures the FIFO and tracks every accepted write/read.
module sync_fifo_monitor #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int STAT_W = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_en,
    input  logic              clr,
    sync_fifo_monitor_if.slave bus,
    output logic [6:0]        err_vec,
    output logic [6:0]        err_sticky,
    output logic              err_any,
    output logic              first_err_vld,
    output logic [2:0]        first_err_code,
    output logic [STAT_W-1:0] wr_acc_cnt,
    output logic [STAT_W-1:0] rd_acc_cnt,
    output logic [STAT_W-1:0] wr_drop_cnt,
    output logic [STAT_W-1:0] rd_drop_cnt
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]    s_cnt;
    logic [AW-1:0]    s_wr;
    logic [AW-1:0]    s_rd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] exp_data;
    logic             exp_vld;

    logic             s_full;
    logic             s_empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             wr_drop;
    logic             rd_drop;
    logic [AW-1:0]    ptr_diff;
    logic [6:0]       chk_now;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    function automatic logic [2:0] low_bit(input logic [6:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign s_full  = (s_cnt == FULL_CNT);
    assign s_empty = (s_cnt == '0);
    assign wr_acc  = bus.fifo_write & ~s_full;
    assign rd_acc  = bus.fifo_read  & ~s_empty;
    assign wr_drop = bus.fifo_write &  s_full;
    assign rd_drop = bus.fifo_read  &  s_empty;

    // Shadow storage is deliberately left unreset; reads are gated by the shadow count.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[s_wr] <= bus.fifo_data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt    <= '0;
            s_wr     <= '0;
            s_rd     <= '0;
            exp_data <= '0;
            exp_vld  <= 1'b0;
        end else begin
            if (wr_acc) s_wr <= s_wr + 1'b1;
            if (rd_acc) begin
                exp_data <= mem[s_rd];
                s_rd     <= s_rd + 1'b1;
            end
            exp_vld <= rd_acc;
            s_cnt   <= s_cnt + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Modulo-DEPTH pointer distance must agree with occupancy (full and empty both alias to 0).
    assign ptr_diff = bus.fifo_wr_ptr - bus.fifo_rd_ptr;

    always_comb begin
        chk_now = '0;
        if (mon_en) begin
            chk_now[0] = bus.fifo_empty != (bus.fifo_cnt == '0);
            chk_now[1] = bus.fifo_full  != (bus.fifo_cnt == FULL_CNT);
            chk_now[2] = bus.fifo_cnt    != s_cnt;
            chk_now[3] = bus.fifo_wr_ptr != s_wr;
            chk_now[4] = bus.fifo_rd_ptr != s_rd;
            chk_now[5] = exp_vld && (bus.fifo_data_out != exp_data);
            chk_now[6] = ptr_diff != bus.fifo_cnt[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_vec        <= '0;
            err_sticky     <= '0;
            first_err_vld  <= 1'b0;
            first_err_code <= '0;
        end else begin
            err_vec <= chk_now;
            if (clr) begin
                err_sticky     <= '0;
                first_err_vld  <= 1'b0;
                first_err_code <= '0;
            end else begin
                err_sticky <= err_sticky | err_vec;
                if (!first_err_vld && (err_vec != '0)) begin
                    first_err_vld  <= 1'b1;
                    first_err_code <= low_bit(err_vec);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_acc_cnt  <= '0;
            rd_acc_cnt  <= '0;
            wr_drop_cnt <= '0;
            rd_drop_cnt <= '0;
        end else if (clr) begin
            wr_acc_cnt  <= '0;
            rd_acc_cnt  <= '0;
            wr_drop_cnt <= '0;
            rd_drop_cnt <= '0;
        end else begin
            wr_acc_cnt  <= sat_inc(wr_acc_cnt,  wr_acc);
            rd_acc_cnt  <= sat_inc(rd_acc_cnt,  rd_acc);
            wr_drop_cnt <= sat_inc(wr_drop_cnt, wr_drop);
            rd_drop_cnt <= sat_inc(rd_drop_cnt, rd_drop);
        end
    end

    assign err_any = |err_sticky;
endmodule
